// File: rtl/uart_rx_byte.sv
// ============================================================================
//  uart_rx_byte
//  8N1 UART receiver: 16x oversampling, start-bit validation, 3-sample
//  majority vote per data bit, stop-bit check, line-break recovery.
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_byte #(
  parameter int CLK_FREQ   = 30000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int OS_DIV     = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  localparam int TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(OS_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s, rx_prev;
  logic [TW-1:0] tick_cnt;
  logic          os_tick;
  logic          start_edge;
  logic [3:0]    s, s_n;
  logic [2:0]    b, b_n;
  logic [2:0]    votes, votes_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          maj;

  // Synchronizer and edge-history flops idle high so reset never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = (state == ST_IDLE) && rx_prev && !rx_s;
  assign os_tick    = (tick_cnt == TICK_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      tick_cnt <= '0;
    else if (start_edge || os_tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  assign maj     = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
  assign rx_busy = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    votes_n = votes;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_n = ST_START;
          s_n     = 4'd0;
        end
      end
      ST_START: begin
        if (os_tick) begin
          s_n = s + 4'd1;
          if (s == 4'd8 && rx_s) begin
            state_n = ST_IDLE;
          end else if (s == 4'd15) begin
            state_n = ST_DATA;
            b_n     = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (os_tick) begin
          s_n = s + 4'd1;
          if (s >= 4'd7 && s <= 4'd9)
            votes_n = {votes[1:0], rx_s};
          if (s == 4'd15) begin
            shreg_n = {maj, shreg[7:1]};
            if (b == 3'd7)
              state_n = ST_STOP;
            else
              b_n = b + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (os_tick) begin
          s_n = s + 4'd1;
          // Decide at mid stop bit so a back-to-back start edge is not missed.
          if (s == 4'd8) begin
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
              s_n     = 4'd0;
            end
          end
        end
      end
      ST_BREAK: begin
        if (!rx_s) begin
          s_n = 4'd0;
        end else if (os_tick) begin
          if (s == 4'd15)
            state_n = ST_IDLE;
          else
            s_n = s + 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      s            <= 4'd0;
      b            <= 3'd0;
      votes        <= 3'd0;
      shreg        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      b            <= b_n;
      votes        <= votes_n;
      shreg        <= shreg_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
//  tb_uart_rx_byte
//  Scoreboard bench for uart_rx_byte at 256 sys_clk per bit.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_byte;

  localparam int BIT_CLK = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int valid_cyc = 0;
  logic prev_pulse = 1'b0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t expq[$];

  uart_rx_byte dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .uart_rx     (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the next expected response.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_frame_err)) begin
      exp_t e;
      check("valid_and_ferr_exclusive", int'(rx_valid && rx_frame_err), 0);
      check("pulse_single_cycle", int'(prev_pulse), 0);
      if (rx_valid) valid_cyc = cyc;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: actual valid=%0b ferr=%0b data=0x%0h required none",
                 rx_valid, rx_frame_err, rx_data);
      end else begin
        e = expq.pop_front();
        check("pulse_kind_ferr", int'(rx_frame_err), int'(e.err));
        check("rx_data", int'(rx_data), int'(e.data));
      end
    end
    prev_pulse = rst_n && (rx_valid || rx_frame_err);
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int spike_bit);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = bits[i];
      if (i == 0) edge_cyc = cyc;
      if (i - 1 == spike_bit) begin
        repeat (128) @(negedge clk);
        rx = ~bits[i];
        @(negedge clk);
        rx = bits[i];
        repeat (126) @(negedge clk);
      end else begin
        repeat (BIT_CLK - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (expq.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, expq.size(), 0);
  endtask

  initial begin
    logic saw_busy;
    logic [9:0] bits;
    int n;

    // Reset, then ten idle bit times.
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * BIT_CLK) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 8'h00);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    check("reset_rx_frame_err", int'(rx_frame_err), 0);

    // 0x41 and its start-edge-to-valid latency (~9.5 bits + sync).
    expq.push_back('{err: 1'b0, data: 8'h41});
    send_frame(8'h41, 1'b1, -1);
    wait_drain("drain_0x41", 600);
    n = valid_cyc - edge_cyc;
    check("latency_in_window", int'(n >= 2430 && n <= 2470), 1);

    // Back-to-back frames: stop bit directly followed by the next start.
    repeat (BIT_CLK) @(negedge clk);
    expq.push_back('{err: 1'b0, data: 8'h55});
    expq.push_back('{err: 1'b0, data: 8'hA3});
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hA3, 1'b1, -1);
    wait_drain("drain_back_to_back", 600);

    // 64-clk low glitch: busy rises, then falls without any pulse.
    repeat (2 * BIT_CLK) @(negedge clk);
    rx = 1'b0;
    saw_busy = 1'b0;
    repeat (64) begin
      @(negedge clk);
      saw_busy |= rx_busy;
    end
    rx = 1'b1;
    repeat (300) begin
      @(negedge clk);
      saw_busy |= rx_busy;
    end
    check("glitch_busy_seen", int'(saw_busy), 1);
    check("glitch_back_to_idle", int'(rx_busy), 0);

    // Framing error then held-low line: a single ferr, data unchanged.
    expq.push_back('{err: 1'b1, data: 8'hA3});
    @(negedge clk);
    rx = 1'b0;
    repeat (10 * BIT_CLK + 5000) @(negedge clk);
    wait_drain("drain_ferr", 10);
    check("break_busy_held", int'(rx_busy), 1);
    rx = 1'b1;
    n = 0;
    while (rx_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("break_release_about_one_bit", int'(n >= 240 && n <= 300), 1);
    repeat (BIT_CLK) @(negedge clk);
    expq.push_back('{err: 1'b0, data: 8'h7E});
    send_frame(8'h7E, 1'b1, -1);
    wait_drain("drain_0x7E", 600);

    // One-clock spike in data bit 3 is voted out.
    repeat (BIT_CLK) @(negedge clk);
    expq.push_back('{err: 1'b0, data: 8'hF0});
    send_frame(8'hF0, 1'b1, 3);
    wait_drain("drain_0xF0_spike", 600);

    // Reset in the middle of data bit 5: immediate reset values, no pulse.
    repeat (BIT_CLK) @(negedge clk);
    bits = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = bits[i];
      repeat (BIT_CLK - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = bits[6];
    repeat (128) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_rx_data", int'(rx_data), 8'h00);
    check("midframe_rst_rx_busy", int'(rx_busy), 0);
    check("midframe_rst_rx_valid", int'(rx_valid), 0);
    check("midframe_rst_rx_frame_err", int'(rx_frame_err), 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("after_reset_idle", int'(rx_busy), 0);
    check("scoreboard_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver: recovers 8N1 bytes from the asynchronous serial line driven by the board's UART transmitter path, or by an external host. It oversamples the line at 16x baud, validates the start bit, majority-votes each data bit and checks the stop bit. Each good byte is presented as a one-cycle valid pulse to downstream logic, for example the LED/echo test top.

Parameters:
CLK_FREQ, 30000000, sys_clk frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, samples per bit; must be 16 (bit-position logic fixed)
OS_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer truncation, =16), sys_clk cycles per oversample tick; must be >= 2

Ports:
sys_clk  input  1  system clock, all logic rising-edge
sys_rst_n  input  1  asynchronous active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to sys_clk
rx_data  output  8  last correctly received byte, LSB first on line
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
rx_busy  output  1  high from start-edge detect until return to IDLE
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (async assert, sync use after deassert): rx_data=0x00, rx_valid=0, rx_busy=0, rx_frame_err=0, state=IDLE, synchronizer flops=1, counters=0.
- uart_rx passes through a 2-flop synchronizer (rx_s), plus one history flop for edge detect; all decisions use rx_s.
- Tick generator: counter 0..OS_DIV-1 emits os_tick on wrap. Forced to 0 on start-edge detect so sampling phase aligns with the edge. Free-runs otherwise.
- Sample counter s (4 bits, 0..15) counts os_ticks within a bit. Bit counter b (3 bits) counts data bits.
- States:
  - IDLE: rx_busy=0. A falling edge on rx_s (1->0) goes to START with s=0 and rx_busy=1 the next cycle.
  - START: on the tick where s==8, rx_s==1 is a glitch: return to IDLE, no pulses. rx_s==0 continues to the end of the bit (s==15) and then goes to DATA with b=0.
  - DATA: capture rx_s on the ticks with s==7, 8 and 9. The bit value is the majority of the three. On s==15 the bit is shifted in LSB-first (shift reg[7]<=bit, right shift). If b==7 go to STOP, else b++.
  - STOP: on s==8 sample rx_s.
    - 1: rx_data<=shift reg, rx_valid=1 for exactly one cycle, go to IDLE. The stop bit's second half is not waited for, so back-to-back frames are caught.
    - 0: rx_frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
  - BREAK: rx_busy stays 1. Remain until rx_s==1 for one full bit (16 consecutive ticks), then go to IDLE. Any 0 restarts the count. This stops a held-low line from generating repeated frames.
- Latency: rx_valid asserts about 9.5 bit periods after the line start edge, plus 2-3 sys_clk cycles of synchronizer delay.
- rx_valid and rx_frame_err are never high together. Neither is ever high for more than one cycle.
- There is no back-pressure. The consumer must take rx_data on rx_valid; rx_data holds until the next good frame.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is dropped with no pulses.
- Counter widths: tick counter ceil(log2(OS_DIV)) bits; the BREAK counter reuses s.

Test Plan:
- Reset, line idle high for 10 bit times (2560 clk at default OS_DIV=16, 256 clk/bit) -> all outputs 0, rx_busy 0.
- Drive 0x41 (start, 1,0,0,0,0,0,1,0, stop) at 256 clk/bit -> exactly one rx_valid pulse; rx_data=0x41 about 2430 clk after start edge; rx_frame_err never 1.
- Send 0x55 then 0xA3 back-to-back (stop bit immediately followed by the next start) -> two rx_valid pulses; rx_data=0x55 then 0xA3.
- Low glitch of 64 clk on idle line -> rx_busy pulses high, then IDLE at the s==8 check; no rx_valid, no rx_frame_err.
- Frame 0x00 with stop bit driven low, then line held low 5000 clk, then high -> one rx_frame_err pulse only, rx_data unchanged; rx_busy falls 256+ clk after the line returns high; a following 0x7E is received correctly.
- Single 1-clk inverted spike mid data bit 3 of 0xF0 -> majority vote still yields rx_data=0xF0. Assert sys_rst_n low during bit 5 of another frame -> outputs reset immediately, no pulse for that frame.
